instruction_loader: RTL and testbench

Writes a program into the 256 x 20-bit instruction memory from a byte stream, such as a UART receiver, before the processor runs. The loader holds the CPU fetch path in reset while it loads. It accepts bytes over a valid/ready handshake and packs every three bytes into one 20-bit instruction. It then issues one-cycle write strobes at sequential addresses starting from 0. When loading finishes it releases the CPU, which resumes fetching at address 0.

---
 rtl/instruction_loader_pkg.sv | 27 ++
 rtl/instruction_loader_if.sv | 28 ++
 rtl/instruction_loader_byte_packer.sv | 49 ++++
 rtl/instruction_loader.sv | 150 +++++++++++++++
 tb/tb_instruction_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared parameters, FSM state encoding and byte-index type for the instruction loader.
// The optional checksum stage is enabled with LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned INS_W         = 20;
  localparam int unsigned BYTES_PER_INS = 3;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RECV  = 3'd1;
  localparam state_t S_WRITE = 3'd2;
  localparam state_t S_CHECK = 3'd3;
  localparam state_t S_FIN   = 3'd4;

  typedef logic [1:0] byte_idx_t;

  // A latched count of zero stands for a full 2**ADDR_W-word load.
  function automatic logic [ADDR_W:0] ins_target(input logic [ADDR_W-1:0] n);
    logic [ADDR_W:0] t;
    t = {1'b0, n};
    if (n == '0) t[ADDR_W] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream, memory-write and status signals between a host and the instruction loader.
interface instruction_loader_if;
  import loader_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   num_ins;
  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [INS_W-1:0]    wdata;
  logic                cpu_hold;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, num_ins, byte_in, byte_valid,
    input  byte_ready, we, waddr, wdata, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, num_ins, byte_in, byte_valid,
    output byte_ready, we, waddr, wdata, cpu_hold, busy, done, err
  );

endinterface

// File: rtl/instruction_loader_byte_packer.sv
// Packs three big-endian bytes into one instruction word; the first byte contributes its low nibble.
module byte_packer
  import loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             byte_stb,
  input  logic [7:0]       byte_in,
  output logic [INS_W-1:0] word,
  output logic             word_complete
);

  localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_INS - 1);

  byte_idx_t        idx_q, idx_d;
  logic [INS_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_stb) begin
      case (idx_q)
        2'd0:    word_d[INS_W-1 -: 4] = byte_in[3:0];
        2'd1:    word_d[15:8]         = byte_in;
        default: word_d[7:0]          = byte_in;
      endcase
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 2'd1;
    end
  end

  // Exposing the next-state word lets the top register it on the same edge as the last byte.
  assign word          = word_d;
  assign word_complete = byte_stb && !clear && (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program into instruction memory from a byte stream while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte after the last word.
module instruction_loader
  import loader_pkg::*;
(
  input  logic                 Clk1,
  input  logic                 Rst,
  instruction_loader_if.slave  bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [INS_W-1:0]  wdata_q, wdata_d;

  logic              byte_ready;
  logic              xfer;
  logic              pk_clear;
  logic              pk_stb;
  logic [INS_W-1:0]  pk_word;
  logic              pk_complete;
  logic              last_ins;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
`endif

  assign byte_ready = (state_q == S_RECV)
`ifdef LOADER_CHECKSUM_EN
                   || (state_q == S_CHECK)
`endif
                   ;
  assign xfer     = bus.byte_valid && byte_ready;
  assign pk_stb   = xfer && (state_q == S_RECV);
  assign last_ins = ({1'b0, addr_q} + (ADDR_W+1)'(1)) == ins_target(num_q);

  byte_packer u_packer (
    .clk           (Clk1),
    .rst           (Rst),
    .clear         (pk_clear),
    .byte_stb      (pk_stb),
    .byte_in       (bus.byte_in),
    .word          (pk_word),
    .word_complete (pk_complete)
  );

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    pk_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RECV;
          num_d    = bus.num_ins;
          addr_d   = '0;
          pk_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d    = '0;
          err_d    = 1'b0;
`endif
        end
      end
      S_RECV: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) sum_d = sum_q + bus.byte_in;
`endif
        if (pk_complete) begin
          state_d = S_WRITE;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = pk_word;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_ins) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_FIN;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          err_d   = (bus.byte_in != sum_q);
          state_d = S_FIN;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk1 or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.cpu_hold   = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FIN);
`ifdef LOADER_CHECKSUM_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader; checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

  logic clk;
  logic rst;

  instruction_loader_if bus ();

  instruction_loader dut (
    .Clk1 (clk),
    .Rst  (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx[$];
  logic [7:0]  wr_addr[$];
  logic [19:0] wr_data[$];
  int          busy_cycles;
  int          done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the memory write port and activity away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) done_cnt++;
      if (bus.we) begin
        wr_addr.push_back(bus.waddr);
        wr_data.push_back(bus.wdata);
        chk("ready_in_write", {31'd0, bus.byte_ready}, 32'd0);
        chk("hold_in_write",  {31'd0, bus.cpu_hold},   32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    repeat (gap) @(posedge clk);
    #1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.byte_ready) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL byte_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = $urandom;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        idle = 1'b1;
        break;
      end
    end
    chk("load_end", {31'd0, idle}, 32'd1);
  endtask

  // Runs one load from tx (topped up with random bytes) and checks writes against the byte grouping rule.
  task automatic run_load(input int n_cfg, input int gap, input bit glitch, input int csum_delta);
    int         n;
    logic [7:0] sum;
    logic [7:0] ck;
    logic [19:0] exp_w;
    int         exp_busy;
    n = (n_cfg == 0) ? 256 : n_cfg;
    while (tx.size() < 3 * n) tx.push_back(8'($urandom));
    wr_addr.delete();
    wr_data.delete();
    busy_cycles = 0;
    done_cnt    = 0;
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.num_ins = n_cfg[7:0];
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.num_ins = 8'd7;
    sum = 8'd0;
    for (int i = 0; i < 3 * n; i++) begin
      if (glitch && i == 4) begin
        bus.start   = 1'b1;
        bus.num_ins = 8'd9;
      end
      send_byte(tx[i], gap);
      if (glitch && i == 4) bus.start = 1'b0;
      sum = sum + tx[i];
    end
`ifdef LOADER_CHECKSUM_EN
    ck = sum + 8'(csum_delta);
    send_byte(ck, 0);
`else
    ck = sum;
`endif
    wait_idle();
    chk("write_count", wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      exp_w = {tx[3*i][3:0], tx[3*i+1], tx[3*i+2]};
      chk("waddr", wr_addr[i], i % 256);
      chk("wdata", wr_data[i], exp_w);
    end
    chk("done_pulses", done_cnt, 1);
    chk("hold_released", {31'd0, bus.cpu_hold}, 32'd0);
    if (gap == 0) begin
      exp_busy = 4 * n + 1;
`ifdef LOADER_CHECKSUM_EN
      exp_busy = exp_busy + 1;
      chk("err", {31'd0, bus.err}, {31'd0, csum_delta != 0});
`endif
      chk("busy_cycles", busy_cycles, exp_busy);
    end
    tx.delete();
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_ins    = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst_we",    {31'd0, bus.we},         32'd0);
    chk("rst_hold",  {31'd0, bus.cpu_hold},   32'd0);
    chk("rst_busy",  {31'd0, bus.busy},       32'd0);
    chk("rst_done",  {31'd0, bus.done},       32'd0);
    chk("rst_err",   {31'd0, bus.err},        32'd0);
    chk("rst_waddr", bus.waddr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed example from the datasheet.
    tx = '{8'h01, 8'h23, 8'h45, 8'h6A, 8'hBC, 8'hDE};
    run_load(2, 0, 1'b0, 0);
    chk("dir_word0", wr_data.size() > 0 ? wr_data[0] : 20'h0, 20'h12345);
    chk("dir_word1", wr_data.size() > 1 ? wr_data[1] : 20'h0, 20'hABCDE);

    // Random small loads, continuous and with a toggling byte_valid.
    run_load(int'($urandom_range(1, 6)), 0, 1'b0, 0);
    run_load(4, 1, 1'b0, 0);

    // Full 256-word load with address wrap.
    run_load(0, 0, 1'b0, 0);
    chk("wrap_last", wr_addr.size() == 256 ? wr_addr[255] : 8'h0, 8'hFF);
    repeat (4) @(negedge clk);
    chk("wrap_no_extra", wr_addr.size(), 256);

    // start while busy must neither restart nor re-latch num_ins.
    run_load(3, 0, 1'b1, 0);

    // Reset in the middle of the second instruction.
    wr_addr.delete();
    wr_data.delete();
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.num_ins = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("mid_rst_we",    {31'd0, bus.we},         32'd0);
    chk("mid_rst_hold",  {31'd0, bus.cpu_hold},   32'd0);
    chk("mid_rst_busy",  {31'd0, bus.busy},       32'd0);
    chk("mid_rst_done",  {31'd0, bus.done},       32'd0);
    chk("mid_rst_waddr", bus.waddr, 32'd0);
    chk("mid_rst_wdata", bus.wdata, 32'd0);
    chk("mid_rst_writes", wr_addr.size(), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_load(2, 0, 1'b0, 0);

`ifdef LOADER_CHECKSUM_EN
    tx = '{8'h01, 8'h02, 8'h03};
    run_load(1, 0, 1'b0, 0);
    tx = '{8'h01, 8'h02, 8'h03};
    run_load(1, 0, 1'b0, 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", {31'd0, bus.err}, 32'd1);
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.num_ins = 8'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("err_cleared", {31'd0, bus.err}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'd0, 0);
    wait_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
